// File: rtl/mult_add_result_fmt.sv
// Output stage for the four-tap multiply-add: tracks valid results, stalls the multiplier
// via clken, rounds/saturates to OUT_W bits and buffers in a small FIFO.
// Optional saturation counter enabled by defining MULT_ADD_RESULT_SAT_CNT_EN.
module mult_add_result_fmt #(
  parameter int IN_W       = 38,
  parameter int OUT_W      = 18,
  parameter int FRAC_SHIFT = 17,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             clken,
  input  logic [IN_W-1:0]  result,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      C_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic signed [IN_W:0]  C_HALF = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [IN_W:0]  C_MAX  = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0]  C_MIN  = ~C_MAX;

  logic [LATENCY-1:0] r_vpipe;
  logic [OUT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               r_satFlag;

  logic               w_push;
  logic               w_pop;
  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_rnd;
  logic signed [IN_W:0] w_q;
  logic               w_satHi;
  logic               w_satLo;
  logic [OUT_W-1:0]   w_fmt;

  // clken has a deliberate combinational path from out_ready: a pop frees the slot
  // the push at the same edge will fill, so a full FIFO keeps streaming.
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign clken     = (r_count != C_FULL) || w_pop;
  assign in_ready  = clken;
  assign w_push    = clken && r_vpipe[LATENCY-1];

  // Extra bit of headroom so the rounding add can never wrap.
  assign w_ext   = {result[IN_W-1], result};
  assign w_rnd   = w_ext + C_HALF;
  assign w_q     = w_rnd >>> FRAC_SHIFT;
  assign w_satHi = (w_q > C_MAX);
  assign w_satLo = (w_q < C_MIN);
  assign w_fmt   = w_satHi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   w_satLo ? {1'b1, {(OUT_W-1){1'b0}}} :
                             w_q[OUT_W-1:0];

  assign out_data = out_valid ? r_mem[r_rdPtr] : '0;
  assign sat_flag = r_satFlag;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_vpipe <= '0;
    end else if (clken) begin
      r_vpipe <= (r_vpipe << 1) | LATENCY'(in_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_fmt;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_satFlag <= 1'b0;
    end else if (sat_clr) begin
      r_satFlag <= 1'b0;
    end else if (w_push && (w_satHi || w_satLo)) begin
      r_satFlag <= 1'b1;
    end
  end

`ifdef MULT_ADD_RESULT_SAT_CNT_EN
  logic [15:0] r_satCnt;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_satCnt <= '0;
    end else if (sat_clr) begin
      r_satCnt <= '0;
    end else if (w_push && (w_satHi || w_satLo) && (r_satCnt != 16'hFFFF)) begin
      r_satCnt <= r_satCnt + 16'd1;
    end
  end

  assign sat_count = r_satCnt;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_mult_add_result_fmt.sv
// Directed bench for mult_add_result_fmt; a three-stage enabled delay line stands in
// for the multiply-add so result lines up with the DUT's valid pipe.
module tb_mult_add_result_fmt;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        in_valid;
  logic        in_ready;
  logic        clken;
  logic [37:0] result;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sat_flag;
  logic        sat_clr;
  logic [15:0] sat_count;

  logic [37:0] din;
  logic [37:0] mpipe [3];

  int total = 0;
  int bad   = 0;

  mult_add_result_fmt dut (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clken    (clken),
    .result   (result),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag (sat_flag),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: frozen by clken exactly like the real one.
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      mpipe[0] <= '0;
      mpipe[1] <= '0;
      mpipe[2] <= '0;
    end else if (clken) begin
      mpipe[0] <= din;
      mpipe[1] <= mpipe[0];
      mpipe[2] <= mpipe[1];
    end
  end

  assign result = mpipe[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [37:0] d, input logic r);
    in_valid  = v;
    din       = d;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runSample(input logic [37:0] v, input logic [17:0] e, input string tag);
    applyStimulus(1'b1, v, 1'b1);
    tick;
    applyStimulus(1'b0, '0, 1'b1);
    tick;
    tick;
    checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
    tick;
    checkOutput({tag, "_vld"}, 32'(out_valid), 32'd1);
    checkOutput(tag, 32'(out_data), 32'(e));
    tick;
  endtask

  logic [15:0] expCnt1;
  logic [15:0] expCnt2;
  int          sent;
  int          nrecv;
  int          idx;
  int          stale;
  logic        acc;
  logic        vpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [37:0] vals [5];
  logic [17:0] expq [3] = '{18'd7, 18'd9, 18'd11};
  logic [24:0] rpat = 25'b111111111111111_0010100100;

  initial begin
`ifdef MULT_ADD_RESULT_SAT_CNT_EN
    expCnt1 = 16'd1;
    expCnt2 = 16'd2;
`else
    expCnt1 = 16'd0;
    expCnt2 = 16'd0;
`endif
    vals[0] = 38'd7 << 17;
    vals[1] = 38'd5 << 17;
    vals[2] = 38'd9 << 17;
    vals[3] = 38'd11 << 17;
    vals[4] = 38'd13 << 17;

    aclr_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1; sat_clr = 1'b0;
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_sat_flag",  32'(sat_flag),  32'd0);
    checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
    checkOutput("rst_clken",     32'(clken),     32'd1);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    aclr_n = 1'b1;
    tick;

    $display("[TB] single sample and rounding");
    runSample(38'h00_0002_0000, 18'h00001, "single");
    checkOutput("single_sat", 32'(sat_flag), 32'd0);
    runSample(38'd65535,        18'h00000, "rnd_p65535");
    runSample(38'd65536,        18'h00001, "rnd_p65536");
    runSample(38'h3F_FFFF_0000, 18'h00000, "rnd_m65536");
    runSample(38'h3F_FFFE_FFFF, 18'h3FFFF, "rnd_m65537");
    checkOutput("rnd_sat", 32'(sat_flag), 32'd0);

    $display("[TB] saturation");
    runSample(38'h10_0000_0000, 18'h1FFFF, "sat_pos");
    checkOutput("sat_pos_flag",  32'(sat_flag),  32'd1);
    checkOutput("sat_pos_count", 32'(sat_count), 32'(expCnt1));
    runSample(38'h20_0000_0000, 18'h20000, "sat_neg");
    checkOutput("sat_neg_flag",  32'(sat_flag),  32'd1);
    checkOutput("sat_neg_count", 32'(sat_count), 32'(expCnt2));
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    #1;
    checkOutput("sat_clr_flag",  32'(sat_flag),  32'd0);
    checkOutput("sat_clr_count", 32'(sat_count), 32'd0);

    $display("[TB] backpressure");
    sent = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(sent < 8, 38'(sent + 1) << 17, 1'b0);
      acc = in_valid && in_ready;
      tick;
      if (acc) sent++;
      if (c == 6) begin
        checkOutput("bp_clken_low", 32'(clken), 32'd0);
        checkOutput("bp_accept7",   32'(sent),  32'd7);
      end
    end
    checkOutput("bp_still7",   32'(sent),      32'd7);
    checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
    checkOutput("bp_hold",     32'(out_data),  32'd1);
    applyStimulus(1'b1, 38'd8 << 17, 1'b1);
    checkOutput("bp_pop_clken", 32'(clken), 32'd1);
    nrecv = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(sent < 8, 38'(sent + 1) << 17, 1'b1);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checkOutput("bp_order", 32'(out_data), 32'(nrecv + 1));
        nrecv++;
      end
      tick;
      if (acc) sent++;
    end
    checkOutput("bp_sent",  32'(sent),      32'd8);
    checkOutput("bp_recv",  32'(nrecv),     32'd8);
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    $display("[TB] valid gaps");
    idx = 0;
    nrecv = 0;
    for (int c = 0; c < 25; c++) begin
      if (idx < 5) applyStimulus(vpat[idx], vals[idx], rpat[c]);
      else         applyStimulus(1'b0, '0, rpat[c]);
      acc = in_ready && (idx < 5);
      if (out_valid && out_ready) begin
        if (nrecv < 3) checkOutput("gap_data", 32'(out_data), 32'(expq[nrecv]));
        nrecv++;
      end
      tick;
      if (acc) idx++;
    end
    checkOutput("gap_count", 32'(nrecv),     32'd3);
    checkOutput("gap_empty", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-stream");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 38'(c + 21) << 17, 1'b0);
      tick;
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick;
    checkOutput("rst_prefill", 32'(out_valid), 32'd1);
    #1;
    aclr_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_data",  32'(out_data),  32'd0);
    checkOutput("rst_async_clken", 32'(clken),     32'd1);
    @(negedge clk);
    aclr_n = 1'b1;
    stale = 0;
    applyStimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick;
      if (out_valid) stale++;
    end
    checkOutput("rst_nostale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
